// File: rtl/up_down_counter_16bit.sv
// Loadable up/down counter with synchronous reset.
// Priority per edge: reset, then parallel load, then count, then hold.
module up_down_counter_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ld_cnt,
    input  logic             updn_cnt,
    input  logic             count_enb,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Each control is compared against an explicit level, so an unknown
    // control falls through to hold instead of acting as asserted.
    always_comb begin
        count_d = count_q;
        if (ld_cnt == 1'b0) begin
            count_d = data_in;
        end else if (ld_cnt == 1'b1 && count_enb == 1'b1) begin
            if (updn_cnt == 1'b1) begin
                count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end else if (updn_cnt == 1'b0) begin
                count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ == 1'b1) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign data_out = count_q;

endmodule

// File: tb/tb_up_down_counter_16bit.sv
// Bench for up_down_counter_16bit: directed corner cases, then random traffic
// compared against an arithmetic reference model.
module tb_up_down_counter_16bit;

    localparam int WIDTH = 16;
    localparam int MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_ = 1'b1;
    logic             ld_cnt = 1'b1;
    logic             updn_cnt = 1'b1;
    logic             count_enb = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;

    int n_checks = 0;
    int n_pass   = 0;
    int model    = 0;

    up_down_counter_16bit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .ld_cnt    (ld_cnt),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Behavioural model: what the count becomes after one edge.
    function automatic int next_count(input int cur, input bit rst, input bit ld_n,
                                      input bit up, input bit en, input int din);
        if (rst)       return 0;
        if (!ld_n)     return din;
        if (!en)       return cur;
        if (up)        return (cur + 1) % MODV;
        return (cur + MODV - 1) % MODV;
    endfunction

    // Apply inputs on the falling edge, let one rising edge pass, check #1 later.
    task automatic step(input string tag, input bit rst, input bit ld_n, input bit up,
                        input bit en, input int din);
        @(negedge clk);
        rst_      = rst;
        ld_cnt    = ld_n;
        updn_cnt  = up;
        count_enb = en;
        data_in   = din[WIDTH-1:0];
        @(posedge clk);
        #1;
        model = next_count(model, rst, ld_n, up, en, din);
        check(tag, data_out, model[WIDTH-1:0]);
        $display("step %-8s rst=%0b ld=%0b up=%0b en=%0b din=%h -> out=%h", tag,
                 rst, ld_n, up, en, din[WIDTH-1:0], data_out);
    endtask

    initial begin
        // Reset with arbitrary other inputs.
        step("reset", 1, 0, 1, 1, 16'h1234);
        check("rst_zero", data_out, 16'h0000);

        // Load beats count.
        step("ld2a", 0, 0, 1, 1, 2);
        step("ld2b", 0, 0, 1, 1, 2);
        check("ld_hold2", data_out, 16'd2);

        for (int i = 0; i < 3; i++) step("up", 0, 1, 1, 1, 16'hBEEF);
        check("up_to5", data_out, 16'd5);
        step("dn", 0, 1, 0, 1, 0);
        step("dn", 0, 1, 0, 1, 0);
        check("dn_to3", data_out, 16'd3);
        for (int i = 0; i < 2; i++) step("up", 0, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) step("hold", 0, 1, i % 2, 0, 16'h5555);
        check("hold5", data_out, 16'd5);

        // Wrap in both directions.
        step("ldFFFE", 0, 0, 0, 0, 16'hFFFE);
        step("up", 0, 1, 1, 1, 0);
        check("upFFFF", data_out, 16'hFFFF);
        step("upwrap", 0, 1, 1, 1, 0);
        check("wrap0", data_out, 16'h0000);
        step("up", 0, 1, 1, 1, 0);
        step("ld0001", 0, 0, 1, 0, 16'h0001);
        step("dn", 0, 1, 0, 1, 0);
        step("dnwrap", 0, 1, 0, 1, 0);
        check("wrapFFFF", data_out, 16'hFFFF);
        step("dn", 0, 1, 0, 1, 0);
        check("dnFFFE", data_out, 16'hFFFE);

        // Reset overrides load and count mid-stream.
        step("ld6", 0, 0, 1, 1, 6);
        step("up7", 0, 1, 1, 1, 0);
        step("rstmid", 1, 0, 1, 1, 16'hAAAA);
        check("rst_ovr", data_out, 16'h0000);
        step("resume", 0, 1, 1, 1, 0);
        check("resume1", data_out, 16'h0001);

        // Reset raised between edges must not act until the next edge.
        step("up2", 0, 1, 1, 1, 0);
        @(negedge clk);
        rst_ = 1'b1;
        #2;
        check("rst_sync", data_out, 16'h0002);
        @(posedge clk);
        #1;
        model = 0;
        check("rst_edge", data_out, 16'h0000);

        // Random traffic, biased toward counting so runs are long enough to matter.
        for (int i = 0; i < 400; i++) begin
            bit rr, ll, uu, ee;
            int dd;
            rr = ($urandom_range(0, 31) == 0);
            ll = ($urandom_range(0, 9) != 0);
            uu = $urandom_range(0, 1);
            ee = ($urandom_range(0, 3) != 0);
            dd = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'hFFFF : 0)
                                             : int'($urandom_range(0, MODV - 1));
            step("rand", rr, ll, uu, ee, dd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/up_down_counter_16bit.md
UP_DOWN_COUNTER_16BIT -- requirements
Module: up_down_counter_16bit

Interface
- REQ-001: Parameter WIDTH, default 16: counter, data_in and data_out width; all requirements below use WIDTH=16.
- REQ-002: One clock; reset is synchronous and active-high.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst_  input  1  synchronous reset, active-high; name kept per codebase convention despite trailing underscore.
- REQ-005: ld_cnt  input  1  load control, active-low; 0 = load data_in, 1 = no load.
- REQ-006: updn_cnt  input  1  count direction; 1 = up, 0 = down.
- REQ-007: count_enb  input  1  count enable, active-high.
- REQ-008: data_in  input  WIDTH  parallel load value.
- REQ-009: data_out  output  WIDTH  current count, driven directly from the count register.

Function
- REQ-010: The count register SHALL update only on the rising edge of clk; data_out SHALL reflect the new value immediately after that edge (1-cycle latency, no combinational input-to-output path).
- REQ-011: Priority per edge SHALL be: rst_=1 > ld_cnt=0 > count_enb=1 > hold.
- REQ-012: With rst_=1 at an edge, count SHALL become 0 regardless of the other inputs.
- REQ-013: With rst_=0 and ld_cnt=0, count SHALL become data_in; count_enb and updn_cnt are ignored that cycle.
- REQ-014: With rst_=0, ld_cnt=1, count_enb=1, updn_cnt=1: count SHALL become count+1 modulo 2^WIDTH.
- REQ-015: With rst_=0, ld_cnt=1, count_enb=1, updn_cnt=0: count SHALL become count-1 modulo 2^WIDTH.
- REQ-016: With rst_=0, ld_cnt=1, count_enb=0: count SHALL hold its value.
- REQ-017: Up wrap: 16'hFFFF counting up SHALL become 16'h0000; down wrap: 16'h0000 counting down SHALL become 16'hFFFF; no flag or saturation.
- REQ-018: A direction change on updn_cnt SHALL take effect at the next enabled edge, with no idle cycle.
- REQ-019: Any input that is X/Z SHALL NOT be treated as asserted; no count, load or reset occurs on a non-1/non-0 control (the bench drives all controls to known values after reset).
- REQ-020: Control behaviour SHALL be purely sequential; no internal state other than the WIDTH-bit count register.

Reset
- REQ-021: Reset SHALL be synchronous: asserting rst_ between edges SHALL NOT change data_out until the next rising edge.
- REQ-022: After reset, data_out SHALL be 16'h0000.
- REQ-023: Reset asserted mid-count or during a load SHALL override both at that edge; counting resumes from 0 on the first edge with rst_=0 and count_enb=1.
- REQ-024: Before the first reset edge, data_out is undefined; the bench SHALL not check it.

Verification
- REQ-025: rst_=1 for 1 edge, other inputs arbitrary -> data_out=0.
- REQ-026: rst_=0, ld_cnt=0, data_in=2, count_enb=1 held for 2 edges -> data_out=2 after each edge (load beats count).
- REQ-027: From 2, ld_cnt=1, count_enb=1, updn_cnt=1 for 3 edges -> data_out 3,4,5; then updn_cnt=0 for 2 edges -> 4,3.
- REQ-028: From 5, count_enb=0, updn_cnt toggling for 4 edges -> data_out stays 5.
- REQ-029: Load 16'hFFFE, count up 3 edges -> FFFF,0000,0001; load 16'h0001, count down 3 edges -> 0000,FFFF,FFFE.
- REQ-030: Counting up from 7, rst_=1 for 1 edge while count_enb=1 and ld_cnt=0 -> data_out=0; next edge with rst_=0, ld_cnt=1, count_enb=1, updn_cnt=1 -> 1.
